// File: rtl/panda_risc_v_ifetch_axi_master.sv
// Instruction-fetch AXI read master: issues single-beat reads for fetch PCs and returns
// instructions in order, silently consuming beats that belong to flushed fetches.
module panda_risc_v_ifetch_axi_master #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned SIM_DELAY       = 1
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic [31:0] fetch_req_pc,
    input  logic        fetch_req_valid,
    output logic        fetch_req_ready,
    input  logic        flush,
    output logic [31:0] fetch_resp_inst,
    output logic [31:0] fetch_resp_pc,
    output logic [1:0]  fetch_resp_err,
    output logic        fetch_resp_valid,
    input  logic        fetch_resp_ready,
    output logic [31:0] m_axi_araddr,
    output logic [1:0]  m_axi_arburst,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] discard_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      pc_fifo [MAX_OUTSTANDING];
    logic             fetch_hs;
    logic             r_hs;
    logic             discarding;
    logic             unused_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Single-beat INCR reads of one 32-bit word; rlast carries no information here.
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'b010;
    assign unused_ok     = ^{m_axi_rlast, 32'(SIM_DELAY)};

    assign discarding       = (discard_cnt != '0);
    assign m_axi_rready     = ~arst & (discarding | fetch_resp_ready);
    assign r_hs             = m_axi_rvalid & m_axi_rready;
    assign fetch_req_ready  = (~m_axi_arvalid | m_axi_arready)
                            & ((cnt < CNT_W'(MAX_OUTSTANDING)) | r_hs)
                            & ~flush & ~arst;
    assign fetch_hs         = fetch_req_valid & fetch_req_ready;

    // Response path is a straight pass-through of the R channel, tagged with the FIFO head PC.
    assign fetch_resp_valid = ~arst & ~discarding & m_axi_rvalid;
    assign fetch_resp_inst  = m_axi_rdata;
    assign fetch_resp_err   = m_axi_rresp;
    assign fetch_resp_pc    = pc_fifo[rd_ptr];

    always_ff @(posedge aclk) begin
        if (arst) begin
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= 32'd0;
            cnt           <= '0;
            discard_cnt   <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
        end else begin
            if (fetch_hs) begin
                m_axi_arvalid <= 1'b1;
                m_axi_araddr  <= {fetch_req_pc[31:2], 2'b00};
            end else if (m_axi_arready) begin
                m_axi_arvalid <= 1'b0;
            end

            cnt <= cnt + CNT_W'(fetch_hs) - CNT_W'(r_hs);

            // A flush marks everything still outstanding as garbage; the beat taken this cycle is kept.
            if (flush) begin
                discard_cnt <= cnt - CNT_W'(r_hs);
            end else if (discarding && r_hs) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end

            if (fetch_hs) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (r_hs) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (fetch_hs) begin
            pc_fifo[wr_ptr] <= fetch_req_pc;
        end
    end

endmodule

// File: doc/panda_risc_v_ifetch_axi_master.md
PANDA_RISC_V_IFETCH_AXI_MASTER -- requirements
Module: panda_risc_v_ifetch_axi_master

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2: maximum reads in flight on the instruction bus (1 or 2).
REQ-002 SHALL have parameter SIM_DELAY, default 1: simulation delay on every register update.
REQ-003 SHALL have one clock and a synchronous, active-high reset: aclk and arst; all state SHALL update on the rising edge of aclk.
REQ-004 aclk  input  1  clock.
REQ-005 arst  input  1  synchronous active-high reset.
REQ-006 fetch_req_pc  input  32  fetch PC.
REQ-007 fetch_req_valid  input  1  fetch request valid.
REQ-008 fetch_req_ready  output  1  fetch request accepted.
REQ-009 flush  input  1  single-cycle pulse that discards all in-flight fetches.
REQ-010 fetch_resp_inst  output  32  instruction word.
REQ-011 fetch_resp_pc  output  32  PC of the returned instruction.
REQ-012 fetch_resp_err  output  2  copy of rresp (00 means OK).
REQ-013 fetch_resp_valid  output  1  response valid.
REQ-014 fetch_resp_ready  input  1  response accepted.
REQ-015 m_axi_araddr, m_axi_arburst, m_axi_arlen, m_axi_arsize, m_axi_arvalid  output  32/2/8/3/1  AXI AR channel to the instruction-memory slave.
REQ-016 m_axi_arready  input  1  AXI AR ready.
REQ-017 m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid  input  32/2/1/1  AXI R channel.
REQ-018 m_axi_rready  output  1  AXI R ready.

Function
REQ-019 SHALL drive constants m_axi_arburst=2'b01, m_axi_arlen=0, m_axi_arsize=3'b010; m_axi_rlast SHALL be ignored.
REQ-020 SHALL register the AR channel: a fetch handshake loads m_axi_araddr={fetch_req_pc[31:2],2'b00} and sets m_axi_arvalid=1 on the next cycle.
REQ-021 Once set, m_axi_arvalid and m_axi_araddr SHALL hold until m_axi_arready, including across flush.
REQ-022 SHALL keep counter cnt (0..MAX_OUTSTANDING) = requests accepted minus R beats handshaken; accept adds 1, R handshake subtracts 1, both in one cycle leaves cnt unchanged.
REQ-023 fetch_req_ready SHALL equal (~m_axi_arvalid | m_axi_arready) & ((cnt < MAX_OUTSTANDING) | R handshake this cycle) & ~flush & ~arst.
REQ-024 SHALL keep a PC FIFO of depth MAX_OUTSTANDING: push on fetch handshake, pop on R handshake; fetch_resp_pc SHALL be the FIFO head (full PC, bits [1:0] preserved).
REQ-025 SHALL keep counter discard_cnt; while discard_cnt>0, m_axi_rready=1, fetch_resp_valid=0, and each R beat decrements discard_cnt and pops the PC FIFO.
REQ-026 While discard_cnt==0: fetch_resp_valid=m_axi_rvalid, m_axi_rready=fetch_resp_ready, fetch_resp_inst=m_axi_rdata, fetch_resp_err=m_axi_rresp; response path combinational, zero added latency.
REQ-027 On flush: discard_cnt <= cnt - (R handshake this cycle ? 1 : 0); a beat handshaken in the flush cycle with discard_cnt==0 SHALL still be delivered.
REQ-028 A flush while discard_cnt>0 SHALL apply the same rule (REQ-027), not accumulate.
REQ-029 cnt SHALL never exceed MAX_OUTSTANDING; an R beat with cnt==0 SHALL NOT occur (protocol violation, behaviour unspecified).
REQ-030 Minimum fetch-to-response latency SHALL be 1 cycle plus slave AR and R latency; with arready always 1, back-to-back accepts SHALL sustain one fetch per cycle when MAX_OUTSTANDING=2 and the slave returns in 1 cycle.

Reset
REQ-031 While arst=1 at a clock edge: m_axi_arvalid<=0, m_axi_araddr<=0, cnt<=0, discard_cnt<=0, PC FIFO emptied.
REQ-032 While arst=1: fetch_req_ready=0, fetch_resp_valid=0, m_axi_rready=0.
REQ-033 Reset asserted mid-transaction SHALL abandon in-flight reads; the slave SHALL be reset in the same domain.

Verification
REQ-034 Single fetch: pc=0x0000_0106, arready=1, slave returns 0x0000_0013 OKAY -> araddr=0x0000_0104; response inst=0x13, pc=0x106, err=0.
REQ-035 Back-pressure: two fetches 0x0,0x4, arready=1; hold fetch_resp_ready=0 five cycles -> rready=0, fetch_req_ready=0 with cnt=2; release -> responses in order, pcs 0x0 then 0x4.
REQ-036 Flush with 2 in flight, no R in flush cycle -> discard_cnt=2; next two beats dropped (rready=1, resp_valid=0); a fetch at 0x80 issued after flush returns pc=0x80.
REQ-037 Flush coinciding with R handshake of the first of 2 in flight -> first beat delivered, discard_cnt=1, second beat dropped.
REQ-038 Error: slave returns rresp=2'b10 -> fetch_resp_err=2'b10 with matching pc; with arready=0 for 3 cycles, araddr and arvalid stay stable across an intervening flush.
REQ-039 Reset mid-flight: arst=1 for one cycle with cnt=2 -> next cycle arvalid=0, fetch_req_ready=1, resp_valid=0.
